uart_tx_serializer: RTL and testbench

//  User-project UART transmitter, the sending end of the link that the testbench UART receiver monitors on mprj_io[6].

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 69 ++++++
 rtl/uart_tx_serializer.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit path.
//   - tx_state_t    : serializer FSM states. PARITY exists only when the
//                     UART_TX_PARITY_EN macro is defined.
//   - UART_DATA_W   : bits per character.
//   - UART_IDLE_LVL : line level while idle, which is also the stop-bit level.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int   UART_DATA_W   = 8;
  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous FIFO that buffers bytes between the valid/ready input and the
//   serializer. The read word is presented combinationally at the head, so a
//   pop takes the word on the same edge. Push and pop may coincide; the level
//   is then unchanged. The caller must not push when full or pop when empty.
// Ports
//   wb_clk_i   in   clock, rising edge
//   wb_rst_i   in   synchronous active-high reset; flushes the FIFO
//   push       in   write push_data on this edge
//   push_data  in   WIDTH-bit word to store
//   pop        in   discard the head word on this edge
//   pop_data   out  head word, valid while !empty
//   full       out  level == DEPTH
//   empty      out  level == 0
//   level      out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap modulo DEPTH for free because DEPTH is a power of two.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are meaningful, so clearing the data would only cost logic.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);

endmodule : uart_tx_fifo

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmitter: bytes accepted on a valid/ready interface are queued in
//   uart_tx_fifo and sent as 8N1, LSB first, idle-high. Back-to-back frames
//   are sent with no idle gap: the next byte is popped on the final cycle of
//   the stop bit.
//   Build option: define UART_TX_PARITY_EN to insert an even-parity bit
//   between the data bits and the stop bit (11-bit frame).
// Ports
//   wb_clk_i    in   clock, rising edge
//   wb_rst_i    in   synchronous active-high reset; aborts any frame, flushes FIFO
//   tx_data     in   byte to send
//   tx_valid    in   tx_data valid
//   tx_ready    out  FIFO not full; a byte is taken when tx_valid & tx_ready
//   tx_o        out  registered serial line, idle 1
//   busy        out  frame in flight or FIFO non-empty
//   fifo_level  out  FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [UART_DATA_W-1:0]       tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         tx_o,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t              state, state_nxt;
  logic [15:0]            baud_cnt, baud_nxt;
  logic [2:0]             bit_idx, bit_idx_nxt;
  logic [UART_DATA_W-1:0] shift_q, shift_nxt;
  logic                   tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_nxt;
`endif

  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [UART_DATA_W-1:0] fifo_head;
  logic                   bit_done;

  assign push     = tx_valid & tx_ready;
  assign tx_ready = ~fifo_full;
  assign busy     = (state != IDLE) | (fifo_level != '0);
  assign bit_done = (baud_cnt == BAUD_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .push      (push),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = bit_done ? '0 : baud_cnt + 16'd1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_q;
    tx_nxt      = tx_o;
    pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt  = parity_q;
`endif

    case (state)
      IDLE: begin
        baud_nxt = '0;
        pop      = ~fifo_empty;
      end
      START: begin
        if (bit_done) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = parity_q;
`else
            state_nxt = STOP;
            tx_nxt    = UART_IDLE_LVL;
`endif
          end else begin
            // Next bit on the wire is the one about to land in shift_q[0].
            shift_nxt   = shift_q >> 1;
            tx_nxt      = shift_q[1];
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          tx_nxt    = UART_IDLE_LVL;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_nxt = IDLE;
          pop       = ~fifo_empty;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = UART_IDLE_LVL;
      end
    endcase

    // A pop (from IDLE or the last stop cycle) loads the byte and drives the
    // start bit on the same edge, so consecutive frames abut.
    if (pop) begin
      state_nxt  = START;
      shift_nxt  = fifo_head;
      tx_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_nxt = ^fifo_head;
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx_o     <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_idx_nxt;
      shift_q  <= shift_nxt;
      tx_o     <= tx_nxt;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_nxt;
`endif
    end
  end

endmodule : uart_tx_serializer

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Self-checking bench for uart_tx_serializer (CLKS_PER_BIT=4, FIFO_DEPTH=4).
//   A table of bytes with hand-derived line patterns is checked cycle by
//   cycle; hand-written sequences cover back-to-back frames, a full FIFO,
//   reset mid-frame and simultaneous push/pop; random traffic is checked by
//   a line receiver plus an occupancy model (bytes accepted - frames begun).
//   Honours UART_TX_PARITY_EN like the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSYM  = 11;
`else
  localparam int NSYM  = 10;
`endif
  localparam int FRAME = NSYM * CPB;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_o, busy;
  logic [2:0] fifo_level;

  uart_tx_serializer #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_o       (tx_o),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge wb_clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model / line receiver ----------------
  logic [7:0] exp_q[$];
  int         start_cyc[$];
  int         n_acc, n_started, n_rx;
  bit         mon_en = 1'b0;
  bit         in_frame = 1'b0;
  bit         saw_full;
  int         sidx;
  logic       line_s [FRAME];

  task automatic decode_frame();
    logic [7:0] b;
    logic [7:0] e;
    bit         stable = 1'b1;
    for (int c = 0; c < NSYM; c++)
      for (int s = 1; s < CPB; s++)
        if (line_s[c*CPB+s] !== line_s[c*CPB]) stable = 1'b0;
    check("bit_cell_stable", stable, 1);
    for (int i = 0; i < 8; i++) b[i] = line_s[(i+1)*CPB];
    check("stop_bit", line_s[(NSYM-1)*CPB], 1);
    check("rx_expected_byte_pending", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rx_byte", b, e);
`ifdef UART_TX_PARITY_EN
      check("parity_bit", line_s[9*CPB], ^e);
`endif
    end
    n_rx++;
  endtask

  always @(negedge wb_clk_i) begin
    int lvl;
    if (!mon_en) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx_o == 1'b0) begin
        in_frame = 1'b1;
        sidx     = 0;
        n_started++;
        start_cyc.push_back(cyc);
      end
      if (in_frame) begin
        line_s[sidx] = tx_o;
        sidx++;
      end
      lvl = n_acc - n_started;
      check("model_level", fifo_level, lvl);
      check("model_ready", tx_ready, lvl < DEPTH);
      check("model_busy", busy, in_frame || lvl != 0);
      if (fifo_level == 3'(DEPTH) && !tx_ready) saw_full = 1'b1;
      if (in_frame && sidx == FRAME) begin
        decode_frame();
        in_frame = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic do_reset();
    mon_en   = 1'b0;
    tx_valid = 1'b0;
    wb_rst_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    exp_q.delete();
    start_cyc.delete();
    n_acc = 0; n_started = 0; n_rx = 0; saw_full = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bit hs;
    int guard = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    do begin
      hs = tx_ready;  // ready is registered, so it holds until the next edge
      @(posedge wb_clk_i);
      #1;
      guard++;
    end while (!hs && guard < 400);
    if (hs) begin
      exp_q.push_back(b);
      n_acc++;
    end else begin
      check("send_timeout", 0, 1);
    end
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_started(input int n, input string name);
    int g = 0;
    while (n_started < n && g < 200) begin
      @(posedge wb_clk_i);
      #1;
      g++;
    end
    check(name, n_started >= n, 1);
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || in_frame || busy) && g < 5000) begin
      @(posedge wb_clk_i);
      #1;
      g++;
    end
    check(name, g < 5000, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit i = i-th symbol on the wire (start, d0..d7, stop)
    logic       par;   // even parity bit
  } vec_t;

  localparam int NTBL = 7;
  vec_t tbl [NTBL];

  initial begin
    logic [10:0] sym;
    logic [7:0]  t0b;
    int          t0;
    bit          stayed_idle;

    tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
    tbl[1] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[2] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[3] = '{8'h01, 10'b1000000010, 1'b1};
    tbl[4] = '{8'h80, 10'b1100000000, 1'b1};
    tbl[5] = '{8'h07, 10'b1000001110, 1'b1};
    tbl[6] = '{8'h03, 10'b1000000110, 1'b0};

    // ---- table: exact line waveform per byte, starting from reset ----
    for (int v = 0; v < NTBL; v++) begin
      do_reset();
      check("reset_tx_o", tx_o, 1);
      check("reset_tx_ready", tx_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_fifo_level", fifo_level, 0);
`ifdef UART_TX_PARITY_EN
      sym = {1'b1, tbl[v].par, tbl[v].line[8:0]};
`else
      sym = {1'b0, tbl[v].line};
`endif
      tx_data  = tbl[v].data;
      tx_valid = 1'b1;
      @(posedge wb_clk_i);  // handshake edge
      #1;
      tx_valid = 1'b0;
      tx_data  = ~tbl[v].data;
      check("tx_o_high_after_handshake", tx_o, 1);
      check("level_after_push", fifo_level, 1);
      check("busy_after_push", busy, 1);
      @(posedge wb_clk_i);  // pop edge: start bit begins
      #1;
      for (int k = 0; k < FRAME; k++) begin
        check("frame_line", tx_o, sym[k/CPB]);
        check("frame_busy", busy, 1);
        @(posedge wb_clk_i);
        #1;
      end
      check("post_frame_tx_o", tx_o, 1);
      check("post_frame_busy", busy, 0);
      check("post_frame_level", fifo_level, 0);
    end

    // ---- back-to-back frames: three pushes on consecutive cycles ----
    do_reset();
    mon_en = 1'b1;
    send(8'h40);
    send(8'h61);
    send(8'h62);
    wait_drain("b2b_drain");
    check("b2b_rx_count", n_rx, 3);
    check("b2b_frame_count", start_cyc.size(), 3);
    if (start_cyc.size() == 3) begin
      check("b2b_gap_0_1", start_cyc[1] - start_cyc[0], FRAME);
      check("b2b_gap_1_2", start_cyc[2] - start_cyc[1], FRAME);
    end

    // ---- overfill: 6 bytes pushed while the first frame is active ----
    do_reset();
    mon_en = 1'b1;
    send(8'($urandom));
    wait_started(1, "full_first_start");
    for (int i = 0; i < 6; i++) send(8'($urandom));
    wait_drain("full_drain");
    check("full_seen_ready_low", saw_full, 1);
    check("full_rx_count", n_rx, 7);

    // ---- reset during DATA of 0xAB with two bytes queued ----
    do_reset();
    send(8'hAB);           // handshake edge N, start bit from edge N+1
    send(8'($urandom));
    send(8'($urandom));    // now at sample k=1 of the 0xAB frame
    repeat (12) begin
      @(posedge wb_clk_i);
      #1;
    end
    check("midframe_bit2_low", tx_o, 0);   // k=13 lies in data bit 2 of 0xAB (0)
    check("midframe_level", fifo_level, 2);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    check("abort_tx_o", tx_o, 1);
    check("abort_level", fifo_level, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", tx_ready, 1);
    stayed_idle = 1'b1;
    repeat (3 * FRAME) begin
      @(posedge wb_clk_i);
      #1;
      if (tx_o !== 1'b1 || busy !== 1'b0) stayed_idle = 1'b0;
    end
    check("abort_no_restart", stayed_idle, 1);

    // ---- push on the final stop edge with one byte queued ----
    do_reset();
    mon_en = 1'b1;
    send(8'h3C);
    wait_started(1, "simul_first_start");
    send(8'hC3);                            // level 1 behind the active frame
    t0 = start_cyc[0];
    while (cyc < t0 + FRAME - 1) begin
      @(posedge wb_clk_i);
      #1;
    end
    t0b = 8'h5A;
    send(t0b);                              // handshake on edge t0+FRAME
    check("simul_level", fifo_level, 1);
    check("simul_next_start", tx_o, 0);
    wait_drain("simul_drain");
    check("simul_rx_count", n_rx, 3);

    // ---- random traffic against the model ----
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, (i % 4 == 0) ? 60 : 3)) begin
        @(posedge wb_clk_i);
        #1;
        tx_data = 8'($urandom);
      end
      send(8'($urandom));
    end
    wait_drain("rand_drain");
    check("rand_rx_count", n_rx, n_acc);
    check("rand_all_accepted", n_acc, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_tx_serializer
